// File: rtl/hue_defect_classifier.sv
// hue_defect_classifier
//   Per-frame hue-window pixel counter with frame-level hysteresis.
//   Each channel counts valid pixels whose hue lies in a programmable,
//   wrap-capable window. At every frame boundary the counts are latched,
//   compared against per-channel thresholds, and the decision is debounced
//   over CONFIRM consecutive evaluated frames.
// Ports
//   video_clk, rst_n      pixel clock, synchronous active-low reset
//   face_vsync, face_de   frame sync (edge into VS_POL = boundary), pixel valid
//   hsv_h                 per-channel hue, ch i = [8i+7:8i]
//   hue_lo, hue_hi        per-channel inclusive window bounds (lo > hi wraps)
//   cnt_thresh            per-channel count threshold, sampled in EVAL
//   frame_cnt             in-window counts of the last closed frame
//   frame_vld             1-cycle pulse: frame evaluated
//   short_frame           1-cycle pulse: frame too small, not evaluated
//   det_flag              debounced per-channel detection

// Per-channel datapath: window compare, saturating count, hysteresis.
module hue_defect_ch #(
    parameter int CNT_W   = 20,
    parameter int CONFIRM = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_en,    // valid pixel while the frame is open
    input  logic [7:0]       hue,
    input  logic [7:0]       lo,
    input  logic [7:0]       hi,
    input  logic [CNT_W-1:0] thresh,
    input  logic             eval,      // latch + clear cycle
    input  logic             judge,     // eval cycle of a large-enough frame
    output logic [CNT_W-1:0] frame_cnt,
    output logic             det
);
    localparam int               RUN_W   = $clog2(CONFIRM + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(CONFIRM);

    logic             in_win, hit, above;
    logic [CNT_W-1:0] cnt;
    logic [RUN_W-1:0] above_run, below_run, above_nxt, below_nxt;

    always_comb begin
        // lo > hi means the window wraps through 255 -> 0
        in_win    = (lo <= hi) ? (hue >= lo && hue <= hi) : (hue >= lo || hue <= hi);
        above     = cnt >= thresh;
        above_nxt = (above_run == RUN_MAX) ? above_run : above_run + RUN_W'(1);
        below_nxt = (below_run == RUN_MAX) ? below_run : below_run + RUN_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit       <= 1'b0;
            cnt       <= '0;
            frame_cnt <= '0;
            above_run <= '0;
            below_run <= '0;
            det       <= 1'b0;
        end else begin
            hit <= pix_en && in_win;
            if (eval) begin
                frame_cnt <= cnt;
                cnt       <= '0;
                if (judge) begin
                    if (above) begin
                        below_run <= '0;
                        above_run <= above_nxt;
                        if (above_nxt == RUN_MAX) det <= 1'b1;
                    end else begin
                        above_run <= '0;
                        below_run <= below_nxt;
                        if (below_nxt == RUN_MAX) det <= 1'b0;
                    end
                end
            end else if (hit && cnt != CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end
endmodule

module hue_defect_classifier #(
    parameter int   NUM_CH  = 3,
    parameter int   H_DISP  = 1024,
    parameter int   V_DISP  = 768,
    parameter int   CNT_W   = 20,
    parameter int   CONFIRM = 3,
    parameter int   MIN_PIX = 393216,
    parameter logic VS_POL  = 1'b1
) (
    input  logic                         video_clk,
    input  logic                         rst_n,
    input  logic                         face_vsync,
    input  logic                         face_de,
    input  logic [NUM_CH-1:0][7:0]       hsv_h,
    input  logic [NUM_CH-1:0][7:0]       hue_lo,
    input  logic [NUM_CH-1:0][7:0]       hue_hi,
    input  logic [NUM_CH-1:0][CNT_W-1:0] cnt_thresh,
    output logic [NUM_CH-1:0][CNT_W-1:0] frame_cnt,
    output logic                         frame_vld,
    output logic                         short_frame,
    output logic [NUM_CH-1:0]            det_flag
);
    // A frame can never hold more than H_DISP*V_DISP pixels, so the minimum
    // is capped there to keep a full frame evaluable.
    localparam int               FRAME_PIX = H_DISP * V_DISP;
    localparam int               MIN_EFF   = (MIN_PIX > FRAME_PIX) ? FRAME_PIX : MIN_PIX;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {IDLE, ACTIVE, CLOSE, EVAL} state_t;

    state_t           state;
    logic             vs_d, de_r, bnd, pix_en, in_eval, tot_ok;
    logic [CNT_W-1:0] tot;

    always_comb begin
        bnd     = (face_vsync == VS_POL) && (vs_d != VS_POL);
        // Only pixels sampled while ACTIVE enter stage 0; CLOSE then drains it.
        pix_en  = face_de && (state == ACTIVE);
        in_eval = (state == EVAL);
        tot_ok  = 32'(tot) >= MIN_EFF;
    end

    always_ff @(posedge video_clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            vs_d        <= 1'b0;
            de_r        <= 1'b0;
            tot         <= '0;
            frame_vld   <= 1'b0;
            short_frame <= 1'b0;
        end else begin
            vs_d        <= face_vsync;
            de_r        <= pix_en;
            frame_vld   <= 1'b0;
            short_frame <= 1'b0;
            if (in_eval)                    tot <= '0;
            else if (de_r && tot != CNT_MAX) tot <= tot + CNT_W'(1);
            case (state)
                IDLE:    if (bnd) state <= ACTIVE;   // first boundary only arms
                ACTIVE:  if (bnd) state <= CLOSE;
                CLOSE:   state <= EVAL;
                EVAL: begin
                    frame_vld   <= tot_ok;
                    short_frame <= !tot_ok;
                    state       <= ACTIVE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    hue_defect_ch #(.CNT_W(CNT_W), .CONFIRM(CONFIRM)) u_ch [NUM_CH-1:0] (
        .clk       (video_clk),
        .rst_n     (rst_n),
        .pix_en    (pix_en),
        .hue       (hsv_h),
        .lo        (hue_lo),
        .hi        (hue_hi),
        .thresh    (cnt_thresh),
        .eval      (in_eval),
        .judge     (in_eval && tot_ok),
        .frame_cnt (frame_cnt),
        .det       (det_flag)
    );
endmodule

// File: tb/tb_hue_defect_classifier.sv
module tb_hue_defect_classifier;
    localparam int NUM_CH  = 3;
    localparam int CNT_W   = 10;
    localparam int CONFIRM = 3;
    localparam int MIN_PIX = 300;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic video_clk = 1'b0;
    logic rst_n = 1'b0, face_vsync = 1'b0, face_de = 1'b0;
    logic [NUM_CH-1:0][7:0]       hsv_h = '0, hue_lo = '0, hue_hi = '0;
    logic [NUM_CH-1:0][CNT_W-1:0] cnt_thresh = '0;
    logic [NUM_CH-1:0][CNT_W-1:0] frame_cnt;
    logic                         frame_vld, short_frame;
    logic [NUM_CH-1:0]            det_flag;

    int n_vec = 0, n_err = 0;

    // reference model state
    int                mcnt [NUM_CH];
    int                mtot;
    bit                armed;
    int                exp_fc [NUM_CH];
    logic [NUM_CH-1:0] exp_det;
    bit                hist [NUM_CH][$];   // last CONFIRM above/below decisions
    int                gen_mode, hit_left, pix_idx;

    hue_defect_classifier #(
        .NUM_CH(NUM_CH), .H_DISP(1024), .V_DISP(768), .CNT_W(CNT_W),
        .CONFIRM(CONFIRM), .MIN_PIX(MIN_PIX), .VS_POL(1'b1)
    ) dut (
        .video_clk(video_clk), .rst_n(rst_n), .face_vsync(face_vsync), .face_de(face_de),
        .hsv_h(hsv_h), .hue_lo(hue_lo), .hue_hi(hue_hi), .cnt_thresh(cnt_thresh),
        .frame_cnt(frame_cnt), .frame_vld(frame_vld), .short_frame(short_frame),
        .det_flag(det_flag)
    );

    always #5 video_clk = ~video_clk;

    initial begin
        #900000;
        $display("FAIL timeout: run did not finish, vectors=%0d", n_vec);
        $fatal(1, "timeout");
    end

    function automatic bit in_win(input int h, input int lo, input int hi);
        if (lo <= hi) return (h >= lo) && (h <= hi);
        return (h >= lo) || (h <= hi);
    endfunction

    task automatic model_clear();
        for (int c = 0; c < NUM_CH; c++) mcnt[c] = 0;
        mtot = 0;
    endtask

    task automatic gen_pixel(input bit de);
        face_de = de;
        for (int c = 0; c < NUM_CH; c++) hsv_h[c] = 8'($urandom_range(0, 255));
        if (de) begin
            case (gen_mode)
                1: begin
                    hsv_h[0] = (hit_left > 0) ? 8'd15 : 8'd100;
                    if (hit_left > 0) hit_left--;
                end
                2: begin
                    hsv_h[0] = (pix_idx % 3 == 0) ? 8'd252 : (pix_idx % 3 == 1) ? 8'd3 : 8'd128;
                    pix_idx++;
                end
                3: for (int c = 0; c < NUM_CH; c++) hsv_h[c] = hue_lo[c];
                default: ;
            endcase
        end
    endtask

    task automatic count_pixel();
        if (face_de) begin
            mtot++;
            for (int c = 0; c < NUM_CH; c++)
                if (in_win(int'(hsv_h[c]), int'(hue_lo[c]), int'(hue_hi[c]))) mcnt[c]++;
        end
    endtask

    task automatic drive_frame(input int npix);
        for (int i = 0; i < npix; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                @(negedge video_clk); gen_pixel(1'b0);
            end
            @(negedge video_clk); gen_pixel(1'b1); count_pixel();
        end
    endtask

    // Frame boundary: vsync rises with a pixel on edge 1, more pixels on
    // edges 2 and 3, results checked after edge 3, pulses gone after edge 4.
    task automatic boundary();
        bit ev_vld, ev_short;
        int t, n_hi;
        @(negedge video_clk); face_vsync = 1'b1; gen_pixel(1'b1);
        if (armed) count_pixel();
        @(posedge video_clk); #1;
        n_vec++;
        if (frame_vld !== 1'b0 || short_frame !== 1'b0) begin
            n_err++;
            $display("FAIL edge1_pulses: vld=%b short=%b, expected 0 0", frame_vld, short_frame);
        end
        if (!armed) model_clear();
        @(negedge video_clk); gen_pixel(1'b1); if (!armed) count_pixel();
        @(negedge video_clk); gen_pixel(1'b1); if (!armed) count_pixel();
        @(posedge video_clk); #1;
        ev_vld = 1'b0; ev_short = 1'b0;
        if (armed) begin
            t = (mtot > CMAX) ? CMAX : mtot;
            for (int c = 0; c < NUM_CH; c++) exp_fc[c] = (mcnt[c] > CMAX) ? CMAX : mcnt[c];
            if (t < MIN_PIX) ev_short = 1'b1;
            else begin
                ev_vld = 1'b1;
                for (int c = 0; c < NUM_CH; c++) begin
                    hist[c].push_back(exp_fc[c] >= int'(cnt_thresh[c]));
                    if (hist[c].size() > CONFIRM) hist[c].delete(0);
                    if (hist[c].size() == CONFIRM) begin
                        n_hi = 0;
                        for (int k = 0; k < hist[c].size(); k++) n_hi += int'(hist[c][k]);
                        if (n_hi == CONFIRM) exp_det[c] = 1'b1;
                        else if (n_hi == 0) exp_det[c] = 1'b0;
                    end
                end
            end
        end
        n_vec++;
        if (frame_vld !== ev_vld || short_frame !== ev_short) begin
            n_err++;
            $display("FAIL edge3_pulses: vld=%b short=%b, expected %b %b",
                     frame_vld, short_frame, ev_vld, ev_short);
        end
        for (int c = 0; c < NUM_CH; c++) begin
            n_vec++;
            if (frame_cnt[c] !== CNT_W'(exp_fc[c])) begin
                n_err++;
                $display("FAIL frame_cnt[%0d]: got %0d, expected %0d", c, frame_cnt[c], exp_fc[c]);
            end
        end
        n_vec++;
        if (det_flag !== exp_det) begin
            n_err++;
            $display("FAIL det_flag: got %b, expected %b", det_flag, exp_det);
        end
        if (armed) model_clear();
        armed = 1'b1;
        @(negedge video_clk); face_de = 1'b0; face_vsync = 1'b0;
        @(posedge video_clk); #1;
        n_vec++;
        if (frame_vld !== 1'b0 || short_frame !== 1'b0) begin
            n_err++;
            $display("FAIL edge4_pulses: vld=%b short=%b, expected 0 0", frame_vld, short_frame);
        end
    endtask

    task automatic test_reset();
        @(negedge video_clk); rst_n = 1'b0; gen_pixel(1'b1);
        @(posedge video_clk); #1;
        n_vec++;
        if (frame_vld !== 1'b0 || short_frame !== 1'b0 || det_flag !== '0 || frame_cnt !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: vld=%b short=%b det=%b cnt=%h, expected all 0",
                     frame_vld, short_frame, det_flag, frame_cnt);
        end
        @(negedge video_clk); rst_n = 1'b1; face_de = 1'b0;
        armed = 1'b0; exp_det = '0;
        for (int c = 0; c < NUM_CH; c++) begin exp_fc[c] = 0; hist[c].delete(); end
        model_clear();
    endtask

    task automatic test_confirm_set();
        hue_lo[0] = 8'd10; hue_hi[0] = 8'd20; cnt_thresh[0] = 10'd400;
        for (int f = 0; f < 4; f++) begin
            gen_mode = 1; hit_left = 500;
            drive_frame(600); boundary();
            n_vec++;
            if (frame_cnt[0] !== 10'd500 || det_flag[0] !== 1'(f >= 2)) begin
                n_err++;
                $display("FAIL confirm_set f%0d: cnt=%0d det=%b, expected 500 %b",
                         f, frame_cnt[0], det_flag[0], 1'(f >= 2));
            end
        end
    endtask

    task automatic test_confirm_clear();
        for (int f = 0; f < 3; f++) begin
            gen_mode = 1; hit_left = 100;
            drive_frame(600); boundary();
            n_vec++;
            if (det_flag[0] !== 1'(f < 2)) begin
                n_err++;
                $display("FAIL confirm_clear f%0d: det=%b, expected %b", f, det_flag[0], 1'(f < 2));
            end
        end
        for (int f = 0; f < 4; f++) begin
            gen_mode = 1; hit_left = (f % 2 == 0) ? 500 : 100;
            drive_frame(600); boundary();
            n_vec++;
            if (det_flag[0] !== 1'b0) begin
                n_err++;
                $display("FAIL alternating f%0d: det=%b, expected 0", f, det_flag[0]);
            end
        end
    endtask

    task automatic test_wrap();
        hue_lo[0] = 8'd250; hue_hi[0] = 8'd5;
        gen_mode = 2; pix_idx = 0;
        drive_frame(899); boundary();   // edge-1 pixel is the 900th (hue 128)
        n_vec++;
        if (frame_cnt[0] !== 10'd600) begin
            n_err++;
            $display("FAIL wrap_window: cnt=%0d, expected 600", frame_cnt[0]);
        end
    endtask

    task automatic test_short();
        logic [NUM_CH-1:0] det_before;
        det_before = exp_det;
        gen_mode = 0;
        drive_frame(100); boundary();
        n_vec++;
        if (det_flag !== det_before) begin
            n_err++;
            $display("FAIL short_det_hold: det=%b, expected %b", det_flag, det_before);
        end
    endtask

    task automatic test_saturation();
        gen_mode = 3;
        drive_frame(1100); boundary();
        for (int c = 0; c < NUM_CH; c++) begin
            n_vec++;
            if (frame_cnt[c] !== CNT_W'(CMAX)) begin
                n_err++;
                $display("FAIL saturation[%0d]: cnt=%0d, expected %0d", c, frame_cnt[c], CMAX);
            end
        end
    endtask

    task automatic test_reset_mid();
        gen_mode = 0;
        drive_frame(200);
        test_reset();
        drive_frame(100); boundary();   // re-arms only
        drive_frame(400); boundary();   // evaluated
    endtask

    task automatic test_random();
        for (int f = 0; f < 6; f++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                hue_lo[c]     = 8'($urandom_range(0, 255));
                hue_hi[c]     = 8'($urandom_range(0, 255));
                cnt_thresh[c] = CNT_W'($urandom_range(0, 350));
            end
            gen_mode = 0;
            drive_frame($urandom_range(250, 700)); boundary();
        end
    endtask

    initial begin
        gen_mode = 0; hit_left = 0; pix_idx = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            hue_lo[c] = 8'(40 * c + 30); hue_hi[c] = 8'(40 * c + 90);
            cnt_thresh[c] = 10'd150;
        end
        test_reset();
        drive_frame(50); boundary();    // first boundary: arm, no evaluation
        test_confirm_set();
        test_confirm_clear();
        test_wrap();
        test_short();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
